free_list_dealloc_buffer: RTL and testbench



---
 rtl/free_list_dealloc_buffer_pkg.sv | 18 +
 rtl/free_list_dealloc_buffer_if.sv | 26 ++
 rtl/free_list_dealloc_buffer_bank_fifo.sv | 52 +++++
 rtl/free_list_dealloc_buffer.sv | 119 +++++++++++
 tb/tb_free_list_dealloc_buffer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/free_list_dealloc_buffer_pkg.sv
// Shared constants for the free-list dealloc front end.
// Holds the register-file geometry (PR count, bank count) and the dealloc
// sizing (commit lanes, per-bank FIFO depth), plus a small width helper.
package free_list_dealloc_buffer_pkg;

    localparam int unsigned PR_COUNT           = 128;
    localparam int unsigned LOG_PR_COUNT       = $clog2(PR_COUNT);
    localparam int unsigned PRF_BANK_COUNT     = 4;
    localparam int unsigned LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
    localparam int unsigned DEALLOC_WIDTH      = 4;
    localparam int unsigned DEALLOC_Q_ENTRIES  = 8;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/free_list_dealloc_buffer_if.sv
// Per-bank enqueue handshake between the dealloc buffer and the free list.
//   enq_valid_by_bank : head of each bank FIFO is valid (master -> slave)
//   enq_PR_by_bank    : head PR of each bank FIFO      (master -> slave)
//   enq_ready_by_bank : free list bank accepts          (slave -> master)
interface free_list_dealloc_buffer_if
    import free_list_dealloc_buffer_pkg::*;
#(
    parameter int unsigned BANKS = PRF_BANK_COUNT,
    parameter int unsigned PR_W  = LOG_PR_COUNT
);
    logic [BANKS-1:0]           enq_valid_by_bank;
    logic [BANKS-1:0][PR_W-1:0] enq_PR_by_bank;
    logic [BANKS-1:0]           enq_ready_by_bank;

    modport master (
        output enq_valid_by_bank,
        output enq_PR_by_bank,
        input  enq_ready_by_bank
    );

    modport slave (
        input  enq_valid_by_bank,
        input  enq_PR_by_bank,
        output enq_ready_by_bank
    );
endinterface

// File: rtl/free_list_dealloc_buffer_bank_fifo.sv
// Multi-push, single-pop circular FIFO for one PRF bank.
//   CLK, RST   : clock, synchronous active-high reset
//   push_count : number of entries written this cycle (0..WIDTH)
//   push_pr    : entries to write, packed from slot 0 upward
//   pop        : remove the head entry
//   head_pr    : head entry, zero while empty
//   occupancy  : current fill level (0..DEPTH)
module dealloc_bank_fifo
    import free_list_dealloc_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = DEALLOC_Q_ENTRIES,
    parameter int unsigned WIDTH  = DEALLOC_WIDTH,
    parameter int unsigned PR_W   = LOG_PR_COUNT,
    localparam int unsigned CNT_W = cnt_bits(WIDTH),
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1
)(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [CNT_W-1:0]           push_count,
    input  logic [WIDTH-1:0][PR_W-1:0] push_pr,
    input  logic                       pop,
    output logic [PR_W-1:0]            head_pr,
    output logic [OCC_W-1:0]           occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PR_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    always_ff @(posedge CLK) begin
        if (RST) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                if (CNT_W'(k) < push_count) begin
                    mem[tail + PTR_W'(k)] <= push_pr[k];
                end
            end
            // Pointers are exactly PTR_W bits, so wrap is modulo DEPTH.
            tail      <= tail + PTR_W'(push_count);
            head      <= head + PTR_W'(pop);
            occupancy <= occupancy + OCC_W'(push_count) - OCC_W'(pop);
        end
    end

    // Masked while empty so the output reads zero after reset.
    assign head_pr = (occupancy != '0) ? mem[head] : '0;

endmodule

// File: rtl/free_list_dealloc_buffer.sv
// Writer-side front end of the banked physical-register free list.
// Steers freed PRs from ROB commit lanes to per-bank FIFOs by PR[low bits]
// and offers one PR per bank per cycle to the free list.
//   CLK, RST              : clock, synchronous active-high reset
//   dealloc_valid_by_lane : lane carries a freed PR
//   dealloc_PR_by_lane    : freed PR per lane
//   dealloc_ready         : all valid lanes are accepted this cycle
//   enq                   : per-bank valid/PR/ready handshake (master side)
//   occupancy_by_bank     : current fill of each bank FIFO
module free_list_dealloc_buffer
    import free_list_dealloc_buffer_pkg::*;
#(
    parameter int unsigned PR_COUNT          = free_list_dealloc_buffer_pkg::PR_COUNT,
    parameter int unsigned PRF_BANK_COUNT    = free_list_dealloc_buffer_pkg::PRF_BANK_COUNT,
    parameter int unsigned DEALLOC_WIDTH     = free_list_dealloc_buffer_pkg::DEALLOC_WIDTH,
    parameter int unsigned DEALLOC_Q_ENTRIES = free_list_dealloc_buffer_pkg::DEALLOC_Q_ENTRIES,
    localparam int unsigned LOG_PR_COUNT     = $clog2(PR_COUNT),
    localparam int unsigned OCC_W            = $clog2(DEALLOC_Q_ENTRIES) + 1
)(
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic [DEALLOC_WIDTH-1:0]                   dealloc_valid_by_lane,
    input  logic [DEALLOC_WIDTH-1:0][LOG_PR_COUNT-1:0] dealloc_PR_by_lane,
    output logic                                       dealloc_ready,
    free_list_dealloc_buffer_if.master                 enq,
    output logic [PRF_BANK_COUNT-1:0][OCC_W-1:0]       occupancy_by_bank
);
    localparam int unsigned LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
    localparam int unsigned CNT_W              = cnt_bits(DEALLOC_WIDTH);
    localparam int unsigned THRESH             = DEALLOC_Q_ENTRIES - DEALLOC_WIDTH;

    logic [DEALLOC_WIDTH-1:0]                                     lane_live;
    logic [DEALLOC_WIDTH-1:0][LOG_PRF_BANK_COUNT-1:0]             lane_bank;
    logic [DEALLOC_WIDTH-1:0][CNT_W-1:0]                          lane_slot;
    logic [PRF_BANK_COUNT-1:0][CNT_W-1:0]                         push_count;
    logic [PRF_BANK_COUNT-1:0][DEALLOC_WIDTH-1:0][LOG_PR_COUNT-1:0] push_pr;
    logic [PRF_BANK_COUNT-1:0]                                    pop;
    logic [PRF_BANK_COUNT-1:0]                                    head_valid;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]                  head_pr;

    // Ready looks only at registered occupancy, leaving room for every lane
    // landing in one bank; no combinational path from the inputs.
    always_comb begin
        dealloc_ready = 1'b1;
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
            if (occupancy_by_bank[b] > OCC_W'(THRESH)) begin
                dealloc_ready = 1'b0;
            end
        end
    end

    // PR 0 is accepted but never buffered.
    always_comb begin
        lane_live = '0;
        lane_bank = '0;
        for (int unsigned i = 0; i < DEALLOC_WIDTH; i++) begin
            lane_live[i] = dealloc_valid_by_lane[i] & dealloc_ready &
                           (dealloc_PR_by_lane[i] != '0);
            lane_bank[i] = dealloc_PR_by_lane[i][LOG_PRF_BANK_COUNT-1:0];
        end
    end

    // Slot of each lane = number of lower live lanes hitting the same bank,
    // which keeps same-bank writes in ascending lane order.
    always_comb begin
        lane_slot  = '0;
        push_count = '0;
        for (int unsigned i = 0; i < DEALLOC_WIDTH; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                if (lane_live[j] && (lane_bank[j] == lane_bank[i])) begin
                    lane_slot[i] = lane_slot[i] + CNT_W'(1);
                end
            end
        end
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int unsigned i = 0; i < DEALLOC_WIDTH; i++) begin
                if (lane_live[i] && (lane_bank[i] == LOG_PRF_BANK_COUNT'(b))) begin
                    push_count[b] = push_count[b] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        push_pr = '0;
        for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int unsigned k = 0; k < DEALLOC_WIDTH; k++) begin
                for (int unsigned i = 0; i < DEALLOC_WIDTH; i++) begin
                    if (lane_live[i] && (lane_bank[i] == LOG_PRF_BANK_COUNT'(b)) &&
                        (lane_slot[i] == CNT_W'(k))) begin
                        push_pr[b][k] = dealloc_PR_by_lane[i];
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
        dealloc_bank_fifo #(
            .DEPTH (DEALLOC_Q_ENTRIES),
            .WIDTH (DEALLOC_WIDTH),
            .PR_W  (LOG_PR_COUNT)
        ) u_fifo (
            .CLK        (CLK),
            .RST        (RST),
            .push_count (push_count[b]),
            .push_pr    (push_pr[b]),
            .pop        (pop[b]),
            .head_pr    (head_pr[b]),
            .occupancy  (occupancy_by_bank[b])
        );
        assign head_valid[b] = (occupancy_by_bank[b] != '0);
        assign pop[b]        = head_valid[b] & enq.enq_ready_by_bank[b];
    end

    assign enq.enq_valid_by_bank = head_valid;
    assign enq.enq_PR_by_bank    = head_pr;

endmodule

// File: tb/tb_free_list_dealloc_buffer.sv
// Self-checking bench for free_list_dealloc_buffer: a directed vector table
// for single push, same-bank burst with ready throttling, PR 0 drop and mixed
// banks, then hand sequences for full-rate drain, mid-stream reset and a long
// random run against a per-bank queue model.
module tb_free_list_dealloc_buffer;

    logic             CLK;
    logic             RST;
    logic [3:0]       dv;
    logic [3:0][6:0]  dpr;
    logic             dr;
    logic [3:0][3:0]  occ;

    int total = 0;
    int bad   = 0;

    free_list_dealloc_buffer_if #(.BANKS(4), .PR_W(7)) enq_if ();

    free_list_dealloc_buffer #(
        .PR_COUNT          (128),
        .PRF_BANK_COUNT    (4),
        .DEALLOC_WIDTH     (4),
        .DEALLOC_Q_ENTRIES (8)
    ) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .dealloc_valid_by_lane (dv),
        .dealloc_PR_by_lane    (dpr),
        .dealloc_ready         (dr),
        .enq                   (enq_if),
        .occupancy_by_bank     (occ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  valid;
        logic [27:0] prs;   // {lane3, lane2, lane1, lane0}
        logic [3:0]  rdy;
        logic [3:0]  ev;
        logic [15:0] eocc;  // {bank3, bank2, bank1, bank0}
        logic [27:0] epr;   // {bank3, bank2, bank1, bank0}
        logic        edr;
    } vec_t;

    vec_t vt [18];

    logic [6:0] q [4][$];
    int         pops [4];
    logic       mready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare against the queue model, then advance the model over one edge.
    task automatic model_cycle();
        mready = 1'b1;
        for (int b = 0; b < 4; b++) if (q[b].size() > 4) mready = 1'b0;
        chk("rnd_ready", {31'd0, dr}, {31'd0, mready});
        for (int b = 0; b < 4; b++) begin
            chk("rnd_occ", {28'd0, occ[b]}, q[b].size());
            chk("rnd_bound", {31'd0, occ[b] > 4'd8}, 32'd0);
            if (q[b].size() > 0) begin
                chk("rnd_valid", {31'd0, enq_if.enq_valid_by_bank[b]}, 32'd1);
                chk("rnd_pr", {25'd0, enq_if.enq_PR_by_bank[b]}, {25'd0, q[b][0]});
            end else begin
                chk("rnd_valid", {31'd0, enq_if.enq_valid_by_bank[b]}, 32'd0);
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (enq_if.enq_ready_by_bank[b] && q[b].size() > 0) begin
                void'(q[b].pop_front());
                pops[b]++;
            end
        end
        if (mready) begin
            for (int i = 0; i < 4; i++) begin
                if (dv[i] && dpr[i] != 7'd0) q[dpr[i][1:0]].push_back(dpr[i]);
            end
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{4'b0001, {7'h00,7'h00,7'h00,7'h05}, 4'b0000, 4'b0010, 16'h0010, {7'h00,7'h00,7'h05,7'h00}, 1'b1};
        vt[1]  = '{4'b0000, 28'd0,                      4'b0010, 4'b0000, 16'h0000, 28'd0,                      1'b1};
        vt[2]  = '{4'b1111, {7'h10,7'h0C,7'h08,7'h04}, 4'b0000, 4'b0001, 16'h0004, {7'h00,7'h00,7'h00,7'h04}, 1'b1};
        vt[3]  = '{4'b1111, {7'h10,7'h0C,7'h08,7'h04}, 4'b0000, 4'b0001, 16'h0008, {7'h00,7'h00,7'h00,7'h04}, 1'b0};
        vt[4]  = '{4'b1111, {7'h10,7'h0C,7'h08,7'h04}, 4'b0001, 4'b0001, 16'h0007, {7'h00,7'h00,7'h00,7'h08}, 1'b0};
        vt[5]  = '{4'b0000, 28'd0,                      4'b0001, 4'b0001, 16'h0006, {7'h00,7'h00,7'h00,7'h0C}, 1'b0};
        vt[6]  = '{4'b0000, 28'd0,                      4'b0001, 4'b0001, 16'h0005, {7'h00,7'h00,7'h00,7'h10}, 1'b0};
        vt[7]  = '{4'b0000, 28'd0,                      4'b0001, 4'b0001, 16'h0004, {7'h00,7'h00,7'h00,7'h04}, 1'b1};
        vt[8]  = '{4'b0000, 28'd0,                      4'b0001, 4'b0001, 16'h0003, {7'h00,7'h00,7'h00,7'h08}, 1'b1};
        vt[9]  = '{4'b0000, 28'd0,                      4'b0001, 4'b0001, 16'h0002, {7'h00,7'h00,7'h00,7'h0C}, 1'b1};
        vt[10] = '{4'b0000, 28'd0,                      4'b0001, 4'b0001, 16'h0001, {7'h00,7'h00,7'h00,7'h10}, 1'b1};
        vt[11] = '{4'b0000, 28'd0,                      4'b0001, 4'b0000, 16'h0000, 28'd0,                      1'b1};
        vt[12] = '{4'b0011, {7'h00,7'h00,7'h40,7'h00}, 4'b0000, 4'b0001, 16'h0001, {7'h00,7'h00,7'h00,7'h40}, 1'b1};
        vt[13] = '{4'b0000, 28'd0,                      4'b1111, 4'b0000, 16'h0000, 28'd0,                      1'b1};
        vt[14] = '{4'b1111, {7'h7F,7'h02,7'h05,7'h01}, 4'b0000, 4'b1110, 16'h1120, {7'h7F,7'h02,7'h01,7'h00}, 1'b1};
        vt[15] = '{4'b1011, {7'h0B,7'h08,7'h06,7'h09}, 4'b0010, 4'b1110, 16'h2220, {7'h7F,7'h02,7'h05,7'h00}, 1'b1};
        vt[16] = '{4'b0000, 28'd0,                      4'b1111, 4'b1110, 16'h1110, {7'h0B,7'h06,7'h09,7'h00}, 1'b1};
        vt[17] = '{4'b0000, 28'd0,                      4'b1111, 4'b0000, 16'h0000, 28'd0,                      1'b1};

        RST = 1'b1;
        dv  = '0;
        dpr = '0;
        enq_if.enq_ready_by_bank = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        chk("reset_occ",   {16'd0, occ}, 32'd0);
        chk("reset_valid", {28'd0, enq_if.enq_valid_by_bank}, 32'd0);
        chk("reset_pr",    {4'd0, enq_if.enq_PR_by_bank}, 32'd0);
        chk("reset_ready", {31'd0, dr}, 32'd1);

        for (int k = 0; k < 18; k++) begin
            dv  = vt[k].valid;
            dpr = vt[k].prs;
            enq_if.enq_ready_by_bank = vt[k].rdy;
            tick();
            chk($sformatf("vec%0d_valid", k), {28'd0, enq_if.enq_valid_by_bank}, {28'd0, vt[k].ev});
            chk($sformatf("vec%0d_occ", k),   {16'd0, occ}, {16'd0, vt[k].eocc});
            chk($sformatf("vec%0d_pr", k),    {4'd0, enq_if.enq_PR_by_bank}, {4'd0, vt[k].epr});
            chk($sformatf("vec%0d_ready", k), {31'd0, dr}, {31'd0, vt[k].edr});
        end

        // Spread lanes, full drain: every bank holds exactly one entry.
        dv  = 4'b1111;
        dpr = {7'h04, 7'h03, 7'h02, 7'h01};
        enq_if.enq_ready_by_bank = 4'b1111;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("spread_ready", {31'd0, dr}, 32'd1);
            chk("spread_occ",   {16'd0, occ}, 32'h0000_1111);
            chk("spread_pr",    {4'd0, enq_if.enq_PR_by_bank}, {4'd0, 7'h03, 7'h02, 7'h01, 7'h04});
        end
        dv = '0;
        tick();
        chk("spread_empty", {16'd0, occ}, 32'd0);

        // Five entries in bank 2, then reset mid-stream.
        enq_if.enq_ready_by_bank = '0;
        dv  = 4'b1111;
        dpr = {7'h0E, 7'h0A, 7'h06, 7'h02};
        tick();
        dv  = 4'b0001;
        dpr = {7'h00, 7'h00, 7'h00, 7'h12};
        tick();
        dv = '0;
        chk("midrst_pre_occ", {16'd0, occ}, 32'h0000_0500);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midrst_occ",   {16'd0, occ}, 32'd0);
        chk("midrst_valid", {28'd0, enq_if.enq_valid_by_bank}, 32'd0);
        chk("midrst_pr",    {4'd0, enq_if.enq_PR_by_bank}, 32'd0);
        chk("midrst_ready", {31'd0, dr}, 32'd1);

        // Random traffic against the queue model.
        for (int b = 0; b < 4; b++) pops[b] = 0;
        for (int c = 0; c < 10000; c++) begin
            dv = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                dpr[i] = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            end
            for (int b = 0; b < 4; b++) begin
                enq_if.enq_ready_by_bank[b] = ($urandom_range(0, 99) < 55);
            end
            model_cycle();
        end
        dv = '0;
        enq_if.enq_ready_by_bank = 4'b1111;
        for (int c = 0; c < 12; c++) model_cycle();
        for (int b = 0; b < 4; b++) begin
            chk("rnd_drained", q[b].size(), 32'd0);
            chk("rnd_wrap", {31'd0, pops[b] > 8}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
